chase_tp_scheduler: RTL and testbench

Sequences test patterns through the shared hard-decision decode pipeline (syndrome → BM → Chien → error-bit saver) one codeword at a time. In mode 0 it issues a single hard decode. In mode 1 (Chase) it issues test patterns 1..4 back-to-back and tracks the best successful candidate. It then pulses the selected pattern index to the output selector (`err_bit_saver_select_tp` / `err_bit_saver_valid_pulse`).

---
 rtl/chase_tp_scheduler.sv | 169 ++++++++++++++++
 tb/tb_chase_tp_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chase_tp_scheduler.sv
// Chase test-pattern scheduler: launches one hard decode (mode 0) or NUM_TP
// back-to-back test patterns (mode 1) and reports the best successful pattern.
module chase_tp_scheduler #(
  parameter int METRIC_W = 12,
  parameter int NUM_TP   = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_mode,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_tp_start,
  output logic [2:0]          o_tp_id,
  input  logic                i_tp_done,
  input  logic                i_tp_fail,
  input  logic [2:0]          i_tp_num_err,
  input  logic [METRIC_W-1:0] i_tp_metric,
  output logic [2:0]          o_select_tp,
  output logic                o_select_valid,
  output logic                o_all_fail
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_REPORT
  } state_t;

  localparam logic [2:0] LAST_TP = 3'(NUM_TP);

  state_t                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [2:0]            tp_cnt_q, tp_cnt_d;
  logic                  best_vld_q, best_vld_d;
  logic [METRIC_W-1:0]   best_metric_q, best_metric_d;
  logic [2:0]            best_nerr_q, best_nerr_d;
  logic [2:0]            best_id_q, best_id_d;

  logic                  busy_q, busy_d;
  logic                  tp_start_q, tp_start_d;
  logic [2:0]            tp_id_q, tp_id_d;
  logic [2:0]            select_tp_q, select_tp_d;
  logic                  select_valid_q, select_valid_d;
  logic                  all_fail_q, all_fail_d;

  logic                  take_cand;
  logic                  upd_vld;
  logic [METRIC_W-1:0]   upd_metric;
  logic [2:0]            upd_nerr;
  logic [2:0]            upd_id;

  // Strict comparisons keep the earlier (lower-index) pattern on full ties.
  always_comb begin
    take_cand  = !i_tp_fail &&
                 (!best_vld_q ||
                  (i_tp_metric < best_metric_q) ||
                  ((i_tp_metric == best_metric_q) && (i_tp_num_err < best_nerr_q)));
    upd_vld    = take_cand ? 1'b1         : best_vld_q;
    upd_metric = take_cand ? i_tp_metric  : best_metric_q;
    upd_nerr   = take_cand ? i_tp_num_err : best_nerr_q;
    upd_id     = take_cand ? tp_cnt_q     : best_id_q;
  end

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    tp_cnt_d       = tp_cnt_q;
    best_vld_d     = best_vld_q;
    best_metric_d  = best_metric_q;
    best_nerr_d    = best_nerr_q;
    best_id_d      = best_id_q;
    tp_id_d        = tp_id_q;
    select_tp_d    = select_tp_q;
    all_fail_d     = all_fail_q;
    select_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        best_vld_d    = 1'b0;
        best_metric_d = '1;
        best_nerr_d   = 3'd7;
        best_id_d     = 3'd1;
        if (i_start) begin
          mode_d   = i_mode;
          tp_cnt_d = i_mode ? 3'd1 : 3'd0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_tp_done) begin
          if (!mode_q) begin
            state_d = ST_IDLE;
          end else begin
            best_vld_d    = upd_vld;
            best_metric_d = upd_metric;
            best_nerr_d   = upd_nerr;
            best_id_d     = upd_id;
            if (tp_cnt_q < LAST_TP) begin
              tp_cnt_d = tp_cnt_q + 3'd1;
              state_d  = ST_ISSUE;
            end else begin
              // The report must already include the pattern finishing now.
              select_tp_d    = upd_id;
              all_fail_d     = ~upd_vld;
              select_valid_d = 1'b1;
              state_d        = ST_REPORT;
            end
          end
        end
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d     = (state_d != ST_IDLE);
    tp_start_d = (state_d == ST_ISSUE);
    if (state_d == ST_ISSUE) begin
      tp_id_d = tp_cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= ST_IDLE;
      mode_q         <= 1'b0;
      tp_cnt_q       <= 3'd0;
      best_vld_q     <= 1'b0;
      best_metric_q  <= '1;
      best_nerr_q    <= 3'd7;
      best_id_q      <= 3'd1;
      busy_q         <= 1'b0;
      tp_start_q     <= 1'b0;
      tp_id_q        <= 3'd0;
      select_tp_q    <= 3'd0;
      select_valid_q <= 1'b0;
      all_fail_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      tp_cnt_q       <= tp_cnt_d;
      best_vld_q     <= best_vld_d;
      best_metric_q  <= best_metric_d;
      best_nerr_q    <= best_nerr_d;
      best_id_q      <= best_id_d;
      busy_q         <= busy_d;
      tp_start_q     <= tp_start_d;
      tp_id_q        <= tp_id_d;
      select_tp_q    <= select_tp_d;
      select_valid_q <= select_valid_d;
      all_fail_q     <= all_fail_d;
    end
  end

  assign o_busy         = busy_q;
  assign o_tp_start     = tp_start_q;
  assign o_tp_id        = tp_id_q;
  assign o_select_tp    = select_tp_q;
  assign o_select_valid = select_valid_q;
  assign o_all_fail     = all_fail_q;

endmodule

// File: tb/tb_chase_tp_scheduler.sv
// Self-checking bench for chase_tp_scheduler: directed scenarios plus random
// codewords checked against a cycle-schedule / best-pick reference model.
module tb_chase_tp_scheduler;

  localparam int METRIC_W = 12;
  localparam int NUM_TP   = 4;

  logic                i_clk = 1'b0;
  logic                i_rst;
  logic                i_mode;
  logic                i_start;
  logic                o_busy;
  logic                o_tp_start;
  logic [2:0]          o_tp_id;
  logic                i_tp_done;
  logic                i_tp_fail;
  logic [2:0]          i_tp_num_err;
  logic [METRIC_W-1:0] i_tp_metric;
  logic [2:0]          o_select_tp;
  logic                o_select_valid;
  logic                o_all_fail;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-pattern decoder results, indexed by pattern id (0 = hard decode).
  bit                  pat_fail   [0:4];
  logic [2:0]          pat_nerr   [0:4];
  logic [METRIC_W-1:0] pat_metric [0:4];

  // Last reported selection, as the outputs should hold it.
  logic [2:0] held_sel = 3'd0;
  logic       held_af  = 1'b0;

  chase_tp_scheduler #(.METRIC_W(METRIC_W), .NUM_TP(NUM_TP)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_mode         (i_mode),
    .i_start        (i_start),
    .o_busy         (o_busy),
    .o_tp_start     (o_tp_start),
    .o_tp_id        (o_tp_id),
    .i_tp_done      (i_tp_done),
    .i_tp_fail      (i_tp_fail),
    .i_tp_num_err   (i_tp_num_err),
    .i_tp_metric    (i_tp_metric),
    .o_select_tp    (o_select_tp),
    .o_select_valid (o_select_valid),
    .o_all_fail     (o_all_fail)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic driveIdleInputs();
    i_start      = 1'b0;
    i_tp_done    = 1'b0;
    i_mode       = 1'($urandom_range(0, 1));
    i_tp_fail    = 1'($urandom_range(0, 1));
    i_tp_num_err = 3'($urandom_range(0, 7));
    i_tp_metric  = METRIC_W'($urandom);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"},      o_busy,         0);
    checkOutput({tag, "_tp_start"},  o_tp_start,     0);
    checkOutput({tag, "_tp_id"},     o_tp_id,        0);
    checkOutput({tag, "_select_tp"}, o_select_tp,    0);
    checkOutput({tag, "_valid"},     o_select_valid, 0);
    checkOutput({tag, "_all_fail"},  o_all_fail,     0);
  endtask

  task automatic setPatterns(input bit f1, input bit f2, input bit f3, input bit f4,
                             input int e1, input int e2, input int e3, input int e4,
                             input int m1, input int m2, input int m3, input int m4);
    pat_fail[1] = f1; pat_fail[2] = f2; pat_fail[3] = f3; pat_fail[4] = f4;
    pat_nerr[1] = 3'(e1); pat_nerr[2] = 3'(e2); pat_nerr[3] = 3'(e3); pat_nerr[4] = 3'(e4);
    pat_metric[1] = METRIC_W'(m1); pat_metric[2] = METRIC_W'(m2);
    pat_metric[3] = METRIC_W'(m3); pat_metric[4] = METRIC_W'(m4);
    pat_fail[0] = 1'($urandom_range(0, 1));
    pat_nerr[0] = 3'($urandom_range(0, 7));
    pat_metric[0] = METRIC_W'($urandom);
  endtask

  // One codeword. Cycle c is the clock period ending at edge c; i_start is
  // sampled at edge 0. Expected schedule and selection come from the rules.
  task automatic applyStimulus(input bit mode, input int lat, input bit abuse);
    int n_pat, valid_c, end_c, starts, valids, done_at, exp_sel;
    bit exp_af;
    int best_m, best_e;
    logic [2:0] done_id;

    n_pat   = mode ? NUM_TP : 1;
    valid_c = mode ? n_pat * (lat + 1) + 1 : -1;
    end_c   = mode ? valid_c + 1 : lat + 2;

    exp_sel = 1;
    exp_af  = 1'b1;
    best_m  = 0;
    best_e  = 0;
    for (int p = 1; p <= n_pat; p++) begin
      if (!pat_fail[p]) begin
        if (exp_af || int'(pat_metric[p]) < best_m ||
            (int'(pat_metric[p]) == best_m && int'(pat_nerr[p]) < best_e)) begin
          exp_sel = p;
          best_m  = int'(pat_metric[p]);
          best_e  = int'(pat_nerr[p]);
          exp_af  = 1'b0;
        end
      end
    end

    starts  = 0;
    valids  = 0;
    done_at = -1;
    done_id = 3'd0;

    @(negedge i_clk);
    driveIdleInputs();
    i_start = 1'b1;
    i_mode  = mode;

    for (int c = 1; c <= end_c + 1; c++) begin
      @(negedge i_clk);
      driveIdleInputs();
      checkOutput($sformatf("busy_c%0d", c), o_busy, (c < end_c) ? 1 : 0);
      if (o_tp_start) begin
        starts++;
        checkOutput($sformatf("start%0d_cycle", starts), c, 1 + (starts - 1) * (lat + 1));
        checkOutput($sformatf("start%0d_id", starts), o_tp_id, mode ? starts : 0);
        done_at = c + lat;
        done_id = o_tp_id;
      end
      if (o_select_valid) begin
        valids++;
        checkOutput("valid_cycle", c, valid_c);
        checkOutput("select_tp", o_select_tp, exp_sel);
        checkOutput("all_fail", o_all_fail, exp_af);
      end
      if (c == done_at) begin
        i_tp_done    = 1'b1;
        i_tp_fail    = pat_fail[done_id];
        i_tp_num_err = pat_nerr[done_id];
        i_tp_metric  = pat_metric[done_id];
      end
      if (abuse && ((c == 3 && c < end_c) || c == (mode ? valid_c : end_c - 1))) begin
        i_start = 1'b1;
      end
    end

    checkOutput("start_count", starts, n_pat);
    checkOutput("valid_count", valids, mode ? 1 : 0);
    if (mode) begin
      held_sel = 3'(exp_sel);
      held_af  = exp_af;
    end
    checkOutput("held_select_tp", o_select_tp, held_sel);
    checkOutput("held_all_fail", o_all_fail, held_af);
  endtask

  // Spurious done pulses in IDLE must not launch anything.
  task automatic idleNoise(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge i_clk);
      checkOutput("idle_busy", o_busy, 0);
      checkOutput("idle_tp_start", o_tp_start, 0);
      driveIdleInputs();
      i_tp_done = 1'b1;
    end
    @(negedge i_clk);
    checkOutput("idle_busy_after", o_busy, 0);
    checkOutput("idle_tp_start_after", o_tp_start, 0);
    driveIdleInputs();
  endtask

  // Reset during a mode 1 run, late done afterwards, then a fresh start.
  task automatic resetMidOp();
    setPatterns(0, 0, 0, 0, 1, 1, 1, 1, 5, 5, 5, 5);
    @(negedge i_clk);
    driveIdleInputs();
    i_start = 1'b1;
    i_mode  = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge i_clk);
      driveIdleInputs();
      i_rst = 1'b0;
      if (c == 4) begin
        i_tp_done    = 1'b1;
        i_tp_fail    = 1'b0;
        i_tp_num_err = 3'd1;
        i_tp_metric  = 12'd5;
      end
      if (c == 7) i_rst = 1'b1;
      if (c == 8) checkAllZero("rst_c8");
      if (c == 9) begin
        checkOutput("rst_c9_busy", o_busy, 0);
        i_tp_done = 1'b1;
      end
      if (c == 10) begin
        checkOutput("rst_c10_busy", o_busy, 0);
        checkOutput("rst_c10_tp_start", o_tp_start, 0);
        i_start = 1'b1;
        i_mode  = 1'b1;
      end
      if (c == 11) begin
        checkOutput("rst_c11_tp_start", o_tp_start, 1);
        checkOutput("rst_c11_tp_id", o_tp_id, 1);
      end
      if (c == 12) begin
        i_rst   = 1'b1;
        i_start = 1'b1;
      end
      if (c == 13) begin
        checkOutput("rst_wins_busy", o_busy, 0);
        checkOutput("rst_wins_tp_start", o_tp_start, 0);
      end
    end
    held_sel = 3'd0;
    held_af  = 1'b0;
  endtask

  initial begin
    bit mode;
    int lat;

    driveIdleInputs();
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    checkAllZero("reset");

    $display("[TB] mode 0, L=5");
    setPatterns(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b0, 5, 1'b0);

    $display("[TB] mode 1, L=3, metric/num_err tie-break");
    setPatterns(0, 0, 0, 0, 2, 3, 1, 1, 40, 25, 25, 60);
    applyStimulus(1'b1, 3, 1'b0);

    $display("[TB] mode 1, all patterns fail");
    setPatterns(1, 1, 1, 1, 0, 0, 0, 0, 1, 2, 3, 4);
    applyStimulus(1'b1, 2, 1'b0);

    $display("[TB] mode 1, full tie with TP1 failed");
    setPatterns(1, 0, 0, 0, 2, 2, 2, 2, 10, 10, 10, 10);
    applyStimulus(1'b1, 1, 1'b0);

    $display("[TB] mode 1, all-ones metric accepted as first candidate");
    setPatterns(1, 0, 1, 0, 7, 6, 0, 7, 0, 4095, 0, 4095);
    applyStimulus(1'b1, 2, 1'b0);

    $display("[TB] protocol abuse");
    setPatterns(0, 1, 0, 0, 3, 0, 3, 2, 9, 1, 9, 9);
    applyStimulus(1'b1, 3, 1'b1);
    idleNoise(3);
    setPatterns(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b0, 4, 1'b1);
    idleNoise(2);

    $display("[TB] reset mid-operation");
    resetMidOp();

    $display("[TB] random codewords");
    for (int n = 0; n < 24; n++) begin
      mode = 1'($urandom_range(0, 1));
      lat  = $urandom_range(1, 6);
      setPatterns($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  ($urandom_range(0, 7) == 0) ? 4095 : $urandom_range(0, 6),
                  ($urandom_range(0, 7) == 0) ? 4095 : $urandom_range(0, 6),
                  ($urandom_range(0, 7) == 0) ? 4095 : $urandom_range(0, 6),
                  ($urandom_range(0, 7) == 0) ? 4095 : $urandom_range(0, 6));
      applyStimulus(mode, lat, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
